chnl_host_emu: RTL

// - Synthesizable stand-in for the RIFFA core side of one user channel: drives CHNL_RX_*, consumes CHNL_TX_*.
// - Per START: sends one RX transaction of LEN words (pattern SEED+k), then accepts one TX transaction and

---
 rtl/chnl_host_emu.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/chnl_host_emu.sv
// ---------------------------------------------------------------------------
// chnl_host_emu
// Stand-in for the RIFFA core side of one user channel. For each START it
// sends one RX transaction of LEN words (word k = SEED+k), then accepts one
// TX transaction and checks it against the loopback-tester return pattern.
//
// Ports
//   CLK, RST               clock / synchronous active-high reset
//   START, LEN, SEED       run request; LEN and SEED latched on acceptance
//   BUSY, DONE             run in progress / one-cycle end-of-run pulse
//   ERR, ERR_COUNT         sticky error flag / saturating error count
//   CHNL_RX*               RX request, attributes and data towards the user
//   CHNL_TX*               TX request, attributes and data from the user
// ---------------------------------------------------------------------------
module chnl_host_emu #(
    parameter int C_PCI_DATA_WIDTH = 128,
    parameter int C_TIMEOUT        = 1024,
    parameter int C_CHECK_TX_DATA  = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        START,
    input  logic [31:0]                 LEN,
    input  logic [31:0]                 SEED,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        ERR,
    output logic [15:0]                 ERR_COUNT,
    output logic                        CHNL_RX,
    input  logic                        CHNL_RX_ACK,
    output logic                        CHNL_RX_LAST,
    output logic [31:0]                 CHNL_RX_LEN,
    output logic [30:0]                 CHNL_RX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    output logic                        CHNL_RX_DATA_VALID,
    input  logic                        CHNL_RX_DATA_REN,
    input  logic                        CHNL_TX,
    output logic                        CHNL_TX_ACK,
    input  logic                        CHNL_TX_LAST,
    input  logic [31:0]                 CHNL_TX_LEN,
    input  logic [30:0]                 CHNL_TX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    input  logic                        CHNL_TX_DATA_VALID,
    output logic                        CHNL_TX_DATA_REN
);
    localparam int          W        = C_PCI_DATA_WIDTH / 32;
    localparam logic [32:0] W33      = 33'(W);
    localparam logic [31:0] TMO_LAST = 32'(C_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RX_REQ, S_RX_DATA, S_TX_WAIT, S_TX_DATA, S_FIN
    } state_t;

    state_t                      state_q, state_d;
    logic [31:0]                 len_q, len_d;
    logic [31:0]                 seed_q, seed_d;
    logic [32:0]                 rx_word_q, rx_word_d;   // index of word 0 of current RX beat
    logic [32:0]                 tx_word_q, tx_word_d;   // index of word 0 of current TX beat
    logic [C_PCI_DATA_WIDTH-1:0] last_rx_q, last_rx_d;   // final RX beat, echoed as TX beat 0
    logic                        err_q, err_d;
    logic [15:0]                 err_cnt_q, err_cnt_d;
    logic [31:0]                 tmo_q, tmo_d;

    logic [C_PCI_DATA_WIDTH-1:0] rx_data;
    logic [C_PCI_DATA_WIDTH-1:0] tx_exp;
    logic [W-1:0]                tx_word_bad;
    logic                        tx_beat_bad;
    logic                        tmo_hit;
    logic                        err_event;
    logic                        start_accept;
    logic                        handshake;
    logic [15:0]                 cnt_base;
    logic                        unused_ok;

    assign unused_ok = &{1'b0, CHNL_TX_LAST, CHNL_TX_OFF};

    // Per-word RX pattern and TX expectation. Words past LEN are still
    // generated on RX but never compared on TX.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_word
            assign rx_data[32*gi +: 32] = seed_q + rx_word_q[31:0] + 32'(gi);
            assign tx_exp[32*gi +: 32]  = (tx_word_q == 33'd0) ? last_rx_q[32*gi +: 32]
                                                               : tx_word_q[31:0] + 32'(gi) + 32'd1;
            assign tx_word_bad[gi] = ((tx_word_q + 33'(gi)) < {1'b0, len_q}) &&
                                     (CHNL_TX_DATA[32*gi +: 32] != tx_exp[32*gi +: 32]);
        end
    endgenerate

    assign tx_beat_bad = (C_CHECK_TX_DATA != 0) && (|tx_word_bad);
    assign tmo_hit     = (C_TIMEOUT != 0) && (tmo_q == TMO_LAST);

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            seed_q    <= '0;
            rx_word_q <= '0;
            tx_word_q <= '0;
            last_rx_q <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            seed_q    <= seed_d;
            rx_word_q <= rx_word_d;
            tx_word_q <= tx_word_d;
            last_rx_q <= last_rx_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        seed_d       = seed_q;
        rx_word_d    = rx_word_q;
        tx_word_d    = tx_word_q;
        last_rx_d    = last_rx_q;
        tmo_d        = tmo_q;
        err_event    = 1'b0;
        start_accept = 1'b0;
        handshake    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    start_accept = 1'b1;
                    len_d        = LEN;
                    seed_d       = SEED;
                    rx_word_d    = '0;
                    tx_word_d    = '0;
                    tmo_d        = '0;
                    if (LEN == 32'd0) begin
                        err_event = 1'b1;
                        state_d   = S_FIN;
                    end else begin
                        state_d = S_RX_REQ;
                    end
                end
            end
            S_RX_REQ: begin
                if (CHNL_RX_ACK) begin
                    handshake = 1'b1;
                    state_d   = S_RX_DATA;
                end
            end
            S_RX_DATA: begin
                if (CHNL_RX_DATA_REN) begin
                    handshake = 1'b1;
                    rx_word_d = rx_word_q + W33;
                    if ((rx_word_q + W33) >= {1'b0, len_q}) begin
                        last_rx_d = rx_data;
                        state_d   = S_TX_WAIT;
                    end
                end
            end
            S_TX_WAIT: begin
                if (CHNL_TX) begin
                    handshake = 1'b1;
                    if (CHNL_TX_LEN != len_q) err_event = 1'b1;
                    state_d = S_TX_DATA;
                end
            end
            S_TX_DATA: begin
                if (CHNL_TX_DATA_VALID) begin
                    handshake = 1'b1;
                    if (tx_beat_bad) err_event = 1'b1;
                    tx_word_d = tx_word_q + W33;
                    if ((tx_word_q + W33) >= {1'b0, len_q}) state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Progress watchdog: any handshake restarts it; expiry aborts the run.
        if (state_q inside {S_RX_REQ, S_RX_DATA, S_TX_WAIT, S_TX_DATA}) begin
            if (handshake) begin
                tmo_d = '0;
            end else if (tmo_hit) begin
                err_event = 1'b1;
                state_d   = S_FIN;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end

        // Simultaneous error sources collapse into one event per cycle.
        cnt_base  = start_accept ? 16'd0 : err_cnt_q;
        err_cnt_d = cnt_base;
        err_d     = start_accept ? 1'b0 : err_q;
        if (err_event) begin
            err_d = 1'b1;
            if (cnt_base != 16'hFFFF) err_cnt_d = cnt_base + 16'd1;
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        BUSY               = (state_q != S_IDLE);
        DONE               = (state_q == S_FIN);
        ERR                = err_q;
        ERR_COUNT          = err_cnt_q;
        CHNL_RX            = (state_q == S_RX_REQ) || (state_q == S_RX_DATA);
        CHNL_RX_LAST       = 1'b1;
        CHNL_RX_LEN        = len_q;
        CHNL_RX_OFF        = '0;
        CHNL_RX_DATA_VALID = (state_q == S_RX_DATA);
        CHNL_RX_DATA       = (state_q == S_RX_DATA) ? rx_data : '0;
        CHNL_TX_ACK        = (state_q == S_TX_WAIT) && CHNL_TX;
        CHNL_TX_DATA_REN   = (state_q == S_TX_DATA);
    end

endmodule
